// File: rtl/dcache_pkg.sv
// Shared state type and address-field helpers for the direct-mapped data-cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_WORDS_BLK = 4;
  localparam int DEF_NUM_LINES = 32;

  // Byte address layout is {tag, idx, off, 2'b00}; widths are passed in so any geometry works.
  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Valid/tag flops for every cache line: combinational lookup port plus one set-valid write port.
module dcache_tag_store #(
  parameter int NUM_LINES = 32,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_valid,
  output logic [TAG_W-1:0] lookup_tag,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TAG_W-1:0] set_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
    end else if (set_valid) begin
      valid_q[set_idx] <= 1'b1;
      tag_q[set_idx]   <= set_tag;
    end
  end

  assign lookup_valid = valid_q[lookup_idx];
  assign lookup_tag   = tag_q[lookup_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache sequencer: hit/miss decision, read-allocate block refill, write-through stores
// without allocation, and the core stall.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int  ADDR_W    = DEF_ADDR_W,
  parameter int  WORDS_BLK = DEF_WORDS_BLK,
  parameter int  NUM_LINES = DEF_NUM_LINES,
  localparam int OFF_W     = $clog2(WORDS_BLK),
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - 2 - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              stall,
  output logic              hit,
  output logic [IDX_W-1:0]  cache_idx,
  output logic [OFF_W-1:0]  cache_off,
  output logic              cache_fill_we,
  output logic              cache_wr_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ack,
  output state_e            dbg_state
);

  // Memory handshake: mem_rd/mem_wr act as "valid" and stay high with mem_addr stable until
  // the cycle mem_ack is high; that cycle completes the transfer and ack is ignored elsewhere.

  state_e           state;
  logic [OFF_W-1:0] cnt;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic             wr_hit;

  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [TAG_W-1:0] req_tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic             lookup_hit;
  logic             refill_done;

  assign req_off = OFF_W'(addr_off(32'(cpu_addr), OFF_W));
  assign req_idx = IDX_W'(addr_idx(32'(cpu_addr), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_tag(32'(cpu_addr), OFF_W, IDX_W));

  assign lookup_hit  = line_valid && (line_tag == req_tag);
  assign refill_done = (state == ST_REFILL) && mem_ack && (cnt == OFF_W'(WORDS_BLK - 1));

  // A line only becomes valid on the final refill ack, so an abandoned refill leaves it invalid.
  dcache_tag_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tag_store (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx   (req_idx),
    .lookup_valid (line_valid),
    .lookup_tag   (line_tag),
    .set_valid    (refill_done),
    .set_idx      (lat_idx),
    .set_tag      (lat_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat_tag <= '0;
      lat_idx <= '0;
      wr_hit  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_wr) begin
            wr_hit <= lookup_hit;
            state  <= ST_WRITE;
          end else if (cpu_rd && !lookup_hit) begin
            lat_tag <= req_tag;
            lat_idx <= req_idx;
            cnt     <= '0;
            state   <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == OFF_W'(WORDS_BLK - 1)) state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst is high so a reset mid-transfer drops requests at once.
  always_comb begin
    stall         = 1'b0;
    hit           = 1'b0;
    cache_idx     = '0;
    cache_off     = '0;
    cache_fill_we = 1'b0;
    cache_wr_we   = 1'b0;
    mem_addr      = '0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (cpu_rd || cpu_wr) begin
            cache_idx = req_idx;
            cache_off = req_off;
            hit       = lookup_hit;
            stall     = cpu_wr || !lookup_hit;
          end
        end
        ST_REFILL: begin
          stall         = 1'b1;
          mem_rd        = 1'b1;
          mem_addr      = {lat_tag, lat_idx, cnt, 2'b00};
          cache_idx     = lat_idx;
          cache_off     = cnt;
          cache_fill_we = mem_ack;
        end
        ST_WRITE: begin
          stall       = !mem_ack;
          mem_wr      = 1'b1;
          mem_addr    = cpu_addr & ~ADDR_W'(3);
          cache_idx   = req_idx;
          cache_off   = req_off;
          cache_wr_we = mem_ack && wr_hit;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
